// File: rtl/rl_ram_1r1w_fwd.sv
// 1R1W RAM with byte-enable writes, per-byte same-cycle write-to-read forwarding
// and a 1- or 2-stage registered read pipeline with output hold.
module rl_ram_1r1w_fwd #(
  parameter int ABITS      = 10,
  parameter int DBITS      = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ABITS-1:0]       waddr_i,
  input  logic [DBITS-1:0]       din_i,
  input  logic                   we_i,
  input  logic [(DBITS+7)/8-1:0] be_i,
  input  logic [ABITS-1:0]       raddr_i,
  input  logic                   re_i,
  output logic [DBITS-1:0]       dout_o,
  output logic                   rvalid_o
);

  localparam int NB    = (DBITS + 7) / 8;
  localparam int PW    = NB * 8;
  localparam int DEPTH = 1 << ABITS;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("rl_ram_1r1w_fwd: RD_LATENCY must be 1 or 2");
  end

  // Storage is padded to whole byte lanes so lane writes use constant-width slices.
  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] din_pad;
  logic [PW-1:0] old_q, old_d;
  logic [PW-1:0] din_q, din_d;
  logic [NB-1:0] mask_q, mask_d;
  logic          v1_q, v1_d;
  logic [PW-1:0] merged;

  always_comb begin
    din_pad = '0;
    din_pad[DBITS-1:0] = din_i;
  end

  // Array write is gated by reset; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i && !rst_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= din_pad[b*8 +: 8];
      end
    end
  end

  // Stage 1 captures pre-write data plus the forward mask and write data;
  // the per-byte merge happens after the register.
  always_comb begin
    old_d  = old_q;
    mask_d = mask_q;
    din_d  = din_q;
    v1_d   = re_i;
    if (re_i) begin
      old_d  = mem_q[raddr_i];
      mask_d = (we_i && (waddr_i == raddr_i)) ? be_i : '0;
      din_d  = din_pad;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      old_q  <= '0;
      mask_q <= '0;
      din_q  <= '0;
      v1_q   <= 1'b0;
    end else begin
      old_q  <= old_d;
      mask_q <= mask_d;
      din_q  <= din_d;
      v1_q   <= v1_d;
    end
  end

  always_comb begin
    merged = old_q;
    for (int b = 0; b < NB; b++) begin
      if (mask_q[b]) merged[b*8 +: 8] = din_q[b*8 +: 8];
    end
  end

  // rvalid_o is a one-cycle strobe: high exactly in the cycle fresh data appears
  // on dout_o; dout_o holds its last value while rvalid_o is low. No backpressure.
  if (RD_LATENCY == 2) begin : g_lat2
    logic [PW-1:0] s2_q, s2_d;
    logic          v2_q, v2_d;

    always_comb begin
      s2_d = v1_q ? merged : s2_q;
      v2_d = v1_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        s2_q <= s2_d;
        v2_q <= v2_d;
      end
    end

    assign dout_o   = s2_q[DBITS-1:0];
    assign rvalid_o = v2_q;
  end else begin : g_lat1
    assign dout_o   = merged[DBITS-1:0];
    assign rvalid_o = v1_q;
  end

endmodule
